// File: rtl/cpu_debug_pkg.sv
// Shared types, default widths and channel-slice helper for the debug DR engine.
package cpu_debug_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIRE  = 2'd2
    } dr_state_e;

    localparam int DEF_DR_W   = 38;
    localparam int DEF_IR_W   = 2;
    localparam int DEF_NUM_CH = 4;

    // Bit offset of channel ch inside a flat array of w-bit words.
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

endpackage

// File: rtl/cpu_debug_edge_det.sv
// Parametrised-width rising-edge detector; history register clears on reset.
module cpu_debug_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] sig_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] hist_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) hist_q <= '0;
        else       hist_q <= sig_i;
    end

    assign rise_o = sig_i & ~hist_q;

endmodule

// File: rtl/cpu_debug_dr_engine.sv
// JTAG-style data-register engine: capture/shift/update with one-hot command pulses.
// Optional parity check on update enabled by macro CPU_DEBUG_DR_PARITY_EN.
module cpu_debug_dr_engine
    import cpu_debug_pkg::*;
#(
    parameter int DR_W   = DEF_DR_W,
    parameter int IR_W   = DEF_IR_W,
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tck_en,
    input  logic                   vs_cdr,
    input  logic                   vs_sdr,
    input  logic                   vs_udr,
    input  logic                   vs_uir,
    input  logic                   tdi,
    input  logic [IR_W-1:0]        ir_in,
    input  logic [NUM_CH*DR_W-1:0] cap_data,
    output logic                   tdo,
    output logic [DR_W-1:0]        jdo,
    output logic [IR_W-1:0]        ir_q,
    output logic [NUM_CH-1:0]      take_action,
    output logic [NUM_CH-1:0]      take_no_action,
    output logic                   len_err,
    output logic                   par_err
);

    localparam int CNT_W = $clog2(DR_W + 2);

    dr_state_e        state_q;
    logic [DR_W-1:0]  sr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       rise;
    logic             cdr_rise, udr_rise, uir_rise;

    cpu_debug_edge_det #(.W(3)) u_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_i  ({vs_uir, vs_udr, vs_cdr}),
        .rise_o (rise)
    );

    assign cdr_rise = rise[0];
    assign udr_rise = rise[1];
    assign uir_rise = rise[2];

    logic [DR_W-1:0]   cap_ch [NUM_CH];
    logic [NUM_CH-1:0] ch_oh;
    logic [DR_W-1:0]   cap_sel;
    logic              ch_valid;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign cap_ch[k] = cap_data[ch_lsb(k, DR_W) +: DR_W];
        assign ch_oh[k]  = (ir_q == IR_W'(k));
    end

    // An out-of-range instruction selects nothing, so capture loads zero.
    always_comb begin
        cap_sel = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (ch_oh[k]) cap_sel = cap_ch[k];
    end

    assign ch_valid = |ch_oh;

`ifdef CPU_DEBUG_DR_PARITY_EN
    logic par_err_q;
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            sr_q           <= '0;
            cnt_q          <= '0;
            tdo            <= 1'b0;
            jdo            <= '0;
            ir_q           <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            len_err        <= 1'b0;
`ifdef CPU_DEBUG_DR_PARITY_EN
            par_err_q      <= 1'b0;
`endif
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            case (state_q)
                IDLE: begin
                    if (uir_rise) begin
                        ir_q    <= ir_in;
                        len_err <= 1'b0;
`ifdef CPU_DEBUG_DR_PARITY_EN
                        par_err_q <= 1'b0;
`endif
                    end
                    if (cdr_rise) begin
                        sr_q    <= cap_sel;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Update wins over a coincident capture.
                    if (udr_rise) begin
                        if (cnt_q != CNT_W'(DR_W)) begin
                            len_err <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            jdo <= sr_q;
`ifdef CPU_DEBUG_DR_PARITY_EN
                            if (^sr_q[DR_W-2:0]) begin
                                par_err_q <= 1'b1;
                                state_q   <= IDLE;
                            end else begin
                                state_q <= FIRE;
                            end
`else
                            state_q <= FIRE;
`endif
                        end
                    end else if (cdr_rise) begin
                        sr_q  <= cap_sel;
                        cnt_q <= '0;
                    end else if (tck_en && vs_sdr) begin
                        sr_q <= {tdi, sr_q[DR_W-1:1]};
                        tdo  <= sr_q[0];
                        if (cnt_q != CNT_W'(DR_W + 1)) cnt_q <= cnt_q + 1'b1;
                    end
                end
                FIRE: begin
                    if (ch_valid) begin
                        if (jdo[DR_W-1]) take_action    <= ch_oh;
                        else             take_no_action <= ch_oh;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_debug_dr_engine.sv
// Self-checking bench: directed literal checks plus randomized traffic against a behavioural model.
module tb_cpu_debug_dr_engine;
    import cpu_debug_pkg::*;

    localparam int DR_W   = DEF_DR_W;
    localparam int IR_W   = DEF_IR_W;
    localparam int NUM_CH = DEF_NUM_CH;

`ifdef CPU_DEBUG_DR_PARITY_EN
    localparam logic [DR_W-1:0] W_ACT = 38'h30_0000_00AB;
`else
    localparam logic [DR_W-1:0] W_ACT = 38'h20_0000_00AB;
`endif
    localparam logic [DR_W-1:0] CAP1 = 38'h15_5555_5555;

    logic clk = 0, reset = 1;
    logic tck_en = 0, vs_cdr = 0, vs_sdr = 0, vs_udr = 0, vs_uir = 0, tdi = 0;
    logic [IR_W-1:0] ir_in = '0;
    logic [NUM_CH*DR_W-1:0] cap_data = '0;
    logic tdo, len_err, par_err;
    logic [DR_W-1:0] jdo;
    logic [IR_W-1:0] ir_q;
    logic [NUM_CH-1:0] take_action, take_no_action;

    int checks = 0, errors = 0;

    cpu_debug_dr_engine #(.DR_W(DR_W), .IR_W(IR_W), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .reset(reset), .tck_en(tck_en),
        .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .tdi(tdi), .ir_in(ir_in), .cap_data(cap_data),
        .tdo(tdo), .jdo(jdo), .ir_q(ir_q),
        .take_action(take_action), .take_no_action(take_no_action),
        .len_err(len_err), .par_err(par_err)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the transaction abstractly: captured word, count of shifts and
    // the list of bits fed in since capture.
    int              m_mode = 0;          // 0 idle, 1 shifting, 2 about to fire
    logic            p_cdr = 0, p_udr = 0, p_uir = 0;
    logic [DR_W-1:0] m_cap = '0;
    int              m_n = 0;
    bit              m_q[$];
    logic            e_tdo = 0, e_len = 0, e_par = 0;
    logic [DR_W-1:0] e_jdo = '0;
    logic [IR_W-1:0] e_ir = '0;
    logic [NUM_CH-1:0] e_ta = '0, e_tna = '0;

    function automatic logic [DR_W-1:0] slice(input logic [NUM_CH*DR_W-1:0] cd, input int ch);
        if (ch >= NUM_CH) return '0;
        return DR_W'(cd >> (ch * DR_W));
    endfunction

    always @(posedge clk) begin
        logic r_cdr, r_udr, r_uir;
        logic [DR_W-1:0] w;
        if (reset) begin
            m_mode = 0; p_cdr = 0; p_udr = 0; p_uir = 0;
            m_cap = '0; m_n = 0; m_q.delete();
            e_tdo = 0; e_len = 0; e_par = 0; e_jdo = '0; e_ir = '0; e_ta = '0; e_tna = '0;
        end else begin
            r_cdr = vs_cdr && !p_cdr;
            r_udr = vs_udr && !p_udr;
            r_uir = vs_uir && !p_uir;
            p_cdr = vs_cdr; p_udr = vs_udr; p_uir = vs_uir;
            e_ta = '0; e_tna = '0;
            if (m_mode == 2) begin
                if (int'(e_ir) < NUM_CH) begin
                    if (e_jdo[DR_W-1]) e_ta[e_ir] = 1'b1;
                    else               e_tna[e_ir] = 1'b1;
                end
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (r_cdr) begin
                    m_cap = slice(cap_data, int'(e_ir));
                    m_n = 0; m_q.delete(); m_mode = 1;
                end
                if (r_uir) begin e_ir = ir_in; e_len = 0; e_par = 0; end
            end else begin
                if (r_udr) begin
                    if (m_n != DR_W) begin
                        e_len = 1; m_mode = 0;
                    end else begin
                        for (int i = 0; i < DR_W; i++) w[i] = m_q[i];
                        e_jdo = w;
                        m_mode = 2;
`ifdef CPU_DEBUG_DR_PARITY_EN
                        if (w[DR_W-2] != (^w[DR_W-3:0])) begin e_par = 1; m_mode = 0; end
`endif
                    end
                end else if (r_cdr) begin
                    m_cap = slice(cap_data, int'(e_ir));
                    m_n = 0; m_q.delete();
                end else if (tck_en && vs_sdr) begin
                    m_n++;
                    e_tdo = (m_n <= DR_W) ? m_cap[m_n-1] : m_q[m_n-1-DR_W];
                    m_q.push_back(tdi);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            cmp("tdo", 64'(tdo), 64'(e_tdo));
            cmp("jdo", 64'(jdo), 64'(e_jdo));
            cmp("ir_q", 64'(ir_q), 64'(e_ir));
            cmp("take_action", 64'(take_action), 64'(e_ta));
            cmp("take_no_action", 64'(take_no_action), 64'(e_tna));
            cmp("len_err", 64'(len_err), 64'(e_len));
            cmp("par_err", 64'(par_err), 64'(e_par));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_uir(input logic [IR_W-1:0] ir);
        ir_in = ir; vs_uir = 1; step(); vs_uir = 0; step();
    endtask

    task automatic do_cdr();
        vs_cdr = 1; step(); vs_cdr = 0; step();
    endtask

    task automatic do_udr();
        vs_udr = 1; step(); vs_udr = 0; step();
    endtask

    task automatic do_shift(input logic [DR_W+7:0] w, input int n, input bit chk_alt);
        vs_sdr = 1;
        for (int i = 0; i < n; i++) begin
            tdi = w[i]; tck_en = 1; step();
            if (chk_alt) cmp($sformatf("tdo_bit%0d", i), 64'(tdo), 64'((i % 2) == 0));
            if ($urandom_range(3, 0) == 0) begin tck_en = 0; step(); end
        end
        tck_en = 0; vs_sdr = 0; step();
    endtask

    task automatic rand_cap();
        for (int k = 0; k < NUM_CH * DR_W; k++) cap_data[k] = 1'($urandom_range(1, 0));
    endtask

    function automatic logic [DR_W+7:0] rand_word();
        logic [DR_W+7:0] w;
        for (int k = 0; k < DR_W + 8; k++) w[k] = 1'($urandom_range(1, 0));
`ifdef CPU_DEBUG_DR_PARITY_EN
        if ($urandom_range(1, 0) == 1) w[DR_W-2] = ^w[DR_W-3:0];
`endif
        return w;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        cmp({tag, "_tdo"}, 64'(tdo), 64'd0);
        cmp({tag, "_jdo"}, 64'(jdo), 64'd0);
        cmp({tag, "_ir"}, 64'(ir_q), 64'd0);
        cmp({tag, "_ta"}, 64'(take_action), 64'd0);
        cmp({tag, "_tna"}, 64'(take_no_action), 64'd0);
        cmp({tag, "_len"}, 64'(len_err), 64'd0);
        cmp({tag, "_par"}, 64'(par_err), 64'd0);
    endtask

    initial begin
        logic [DR_W+7:0] w;
        int len;
        step(3);
        chk_reset_outputs("rst0");
        reset = 0; step();

        // Capture alternating pattern on channel 1, shift in the action word.
        cap_data = '0;
        cap_data[ch_lsb(1, DR_W) +: DR_W] = CAP1;
        do_uir(2'd1);
        cmp("ir_loaded", 64'(ir_q), 64'd1);
        do_cdr();
        do_shift({8'h00, W_ACT}, DR_W, 1'b1);
        vs_udr = 1; step();
        cmp("jdo_commit", 64'(jdo), 64'(W_ACT));
        cmp("ta_early", 64'(take_action), 64'd0);
        vs_udr = 0; step();
        cmp("ta_pulse", 64'(take_action), 64'b0010);
        cmp("tna_pulse", 64'(take_no_action), 64'd0);
        step();
        cmp("ta_cleared", 64'(take_action), 64'd0);

        // Short shift: length error, jdo held, cleared by next IR update.
        do_cdr();
        do_shift(rand_word(), DR_W - 1, 1'b0);
        do_udr(); step(2);
        cmp("len_err_set", 64'(len_err), 64'd1);
        cmp("len_jdo_held", 64'(jdo), 64'(W_ACT));
        do_uir(2'd1);
        cmp("len_err_clr", 64'(len_err), 64'd0);

        // Reset in mid-shift.
        do_cdr();
        do_shift(rand_word(), 20, 1'b0);
        reset = 1; #1;
        chk_reset_outputs("rst_mid");
        step(); reset = 0; step();
        do_udr(); step(2);
        cmp("rst_no_pulse_ta", 64'(take_action), 64'd0);
        cmp("rst_no_len", 64'(len_err), 64'd0);

`ifdef CPU_DEBUG_DR_PARITY_EN
        do_uir(2'd1);
        do_cdr();
        do_shift({8'h00, 38'h00_0000_0001}, DR_W, 1'b0);
        vs_udr = 1; step(); vs_udr = 0; step();
        cmp("par_err_set", 64'(par_err), 64'd1);
        cmp("par_jdo", 64'(jdo), 64'h1);
        cmp("par_no_ta", 64'(take_action | take_no_action), 64'd0);
        do_uir(2'd1);
        cmp("par_err_clr", 64'(par_err), 64'd0);
        do_cdr();
        do_shift({8'h00, 38'h10_0000_0001}, DR_W, 1'b0);
        vs_udr = 1; step(); vs_udr = 0; step();
        cmp("par_tna_pulse", 64'(take_no_action), 64'b0010);
        step();
`endif

        // Randomized transactions.
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(6, 0))
                0: do_uir(IR_W'($urandom_range(2**IR_W - 1, 0)));
                1: begin rand_cap(); do_cdr(); end
                2: do_shift(rand_word(), $urandom_range(DR_W + 3, 1), 1'b0);
                3: do_udr();
                4, 5: begin
                    rand_cap(); do_cdr();
                    case ($urandom_range(3, 0))
                        0: len = DR_W - 1;
                        1: len = DR_W + 1 + $urandom_range(2, 0);
                        default: len = DR_W;
                    endcase
                    do_shift(rand_word(), len, 1'b0);
                    do_udr(); step($urandom_range(2, 0));
                end
                default: begin
                    if ($urandom_range(15, 0) == 0) begin reset = 1; step(); reset = 0; end
                    step($urandom_range(3, 1));
                end
            endcase
        end

        // Free-running strobe noise to hit coincident edges and FIRE-time strobes.
        for (int c = 0; c < 3000; c++) begin
            if ((c % 200) == 0) rand_cap();
            vs_cdr = ($urandom_range(15, 0) == 0);
            vs_udr = ($urandom_range(15, 0) == 0);
            vs_uir = ($urandom_range(31, 0) == 0);
            vs_sdr = ($urandom_range(3, 0) != 0);
            tck_en = ($urandom_range(1, 0) == 1);
            tdi    = 1'($urandom_range(1, 0));
            ir_in  = IR_W'($urandom_range(2**IR_W - 1, 0));
            step();
        end
        vs_cdr = 0; vs_udr = 0; vs_uir = 0; vs_sdr = 0; tck_en = 0;
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
